// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
// Widths mirror the REG_BUS / INST_BUS conventions of the surrounding pipeline.
package inst_queue_pkg;

    localparam int unsigned REG_BUS_W  = 64;
    localparam int unsigned INST_BUS_W = 32;
    localparam int unsigned IQ_DEPTH   = 4;

    localparam logic [INST_BUS_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IQ_IDLE = 2'b00,
        IQ_PUSH = 2'b01,
        IQ_POP  = 2'b10,
        IQ_BOTH = 2'b11
    } iq_op_e;

    function automatic iq_op_e decode_op(input logic push, input logic pop);
        return iq_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/inst_queue.sv
// In-order instruction queue between fetch and decode with single-cycle flush.
// Status outputs and the head mux depend only on registered state.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = IQ_DEPTH,
    parameter int unsigned PC_W   = REG_BUS_W,
    parameter int unsigned INST_W = INST_BUS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [INST_W-1:0] NOP_W    = INST_W'(NOP_INST);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    iq_op_e            op;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);

    always_comb begin
        push = in_valid && in_ready && !flush;
        pop  = out_valid && out_ready && !flush;
        op   = decode_op(push, pop);
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case (op)
                IQ_PUSH: count <= count + 1'b1;
                IQ_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Empty queue presents a NOP at PC 0 so decode never sees stale storage.
    always_comb begin
        out_pc   = '0;
        out_inst = NOP_W;
        if (out_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed scoreboard bench for inst_queue: the stimulus queues expected head
// entries, an independent monitor pops them whenever decode consumes the head.
module tb_inst_queue;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    entry_t      sb [$];

    inst_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_for(input logic [63:0] pc);
        return {pc[11:0], 20'h00093};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a push; the caller states whether the queue is expected to accept it.
    task automatic drive_push(input logic [63:0] pc, input bit accept);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst_for(pc);
        if (accept)
            sb.push_back('{pc: pc, inst: inst_for(pc)});
    endtask

    initial begin : monitor
        entry_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", out_pc, 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = sb.pop_front();
                    check("pop_entry", {out_pc[31:0], out_inst}, {e.pc[31:0], e.inst});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'h13);
        check("rst_out_pc", out_pc, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill to DEPTH with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive_push(64'h8000_0000 + 64'(4 * i), 1'b1);
            tick();
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_head_pc", out_pc, 64'h8000_0000);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive_push(64'h8000_0010, 1'b0);
        tick();
        check("full_count", 64'(count), 64'd4);
        check("full_head_pc", out_pc, 64'h8000_0000);
        check("full_head_inst", 64'(out_inst), 64'(inst_for(64'h8000_0000)));
        in_valid = 1'b0;

        // Drain in order.
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_out_inst", 64'(out_inst), 64'h13);
        check("drain_count", 64'(count), 64'd0);

        // Streaming: push and pop every cycle, pointers wrap three times.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_push(64'h8000_0040 + 64'(4 * i), 1'b1);
            tick();
            check("stream_count", 64'(count), 64'd1);
            check("stream_head_pc", out_pc, 64'h8000_0040 + 64'(4 * i));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_end_count", 64'(count), 64'd0);

        // Flush beats a simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive_push(64'h8000_0100 + 64'(4 * i), 1'b1);
            tick();
        end
        check("preflush_count", 64'(count), 64'd3);
        drive_push(64'h8000_0200, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        drive_push(64'h8000_1000, 1'b1);
        tick();
        in_valid = 1'b0;
        check("postflush_valid", 64'(out_valid), 64'd1);
        check("postflush_pc", out_pc, 64'h8000_1000);
        check("postflush_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges.
        for (int i = 0; i < 2; i++) begin
            drive_push(64'h8000_0300 + 64'(4 * i), 1'b1);
            tick();
        end
        in_valid = 1'b0;
        check("prereset_count", 64'(count), 64'd2);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        check("async_out_inst", 64'(out_inst), 64'h13);
        tick();
        @(negedge clk);
        rst = 1'b1;
        drive_push(64'h8000_0400, 1'b1);
        tick();
        in_valid = 1'b0;
        check("fresh_count", 64'(count), 64'd1);
        check("fresh_pc", out_pc, 64'h8000_0400);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
